// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared definitions for the processing-element datapath:
//                sequencer state encodings, default memory bases and word
//                width, plus a counter-width helper.
//  Config      : none
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    // Sequencer states shared by the im2col / col2im passes
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] OUTPUT_BASE_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] FMAP_BASE_DEFAULT   = 32'h0000_4000;
    localparam int          DATA_WIDTH_DEFAULT  = 32;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pe_pkg
`default_nettype wire

// File: rtl/col2im_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : col2im_addr_gen
//  Description : Nested pixel/filter counters for the col2im pass. Produces
//                the source read address (row-major result matrix) and the
//                destination address (channel-major feature map) for the
//                current (p,f), and flags the last issue of a pass.
//  Config      : none
//  Revision    : 1.0 - initial release
// ============================================================================
module col2im_addr_gen
    import pe_pkg::*;
#(
    parameter int                    IMG_H       = 5,
    parameter int                    IMG_W       = 5,
    parameter int                    FILTER_NUM  = 7,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(OUTPUT_BASE_DEFAULT),
    parameter logic [ADDR_WIDTH-1:0] FMAP_BASE   = ADDR_WIDTH'(FMAP_BASE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [ADDR_WIDTH-1:0] dest_addr,
    output logic                  last_issue
);

    localparam int M  = IMG_H * IMG_W;
    localparam int K  = FILTER_NUM;
    localparam int PW = cnt_width(M);
    localparam int FW = cnt_width(K);

    localparam logic [PW-1:0] P_LAST = PW'(M - 1);
    localparam logic [FW-1:0] F_LAST = FW'(K - 1);
    localparam logic [ADDR_WIDTH-1:0] K_A = ADDR_WIDTH'(K);
    localparam logic [ADDR_WIDTH-1:0] M_A = ADDR_WIDTH'(M);

    logic [PW-1:0] p_q, p_d;
    logic [FW-1:0] f_q, f_d;
    logic [ADDR_WIDTH-1:0] p_ext;
    logic [ADDR_WIDTH-1:0] f_ext;

    // Next counter values: f is inner and wraps into p; the counters park on
    // the final (p,f) so the read address is held once the pass ends
    always_comb begin
        p_d = p_q;
        f_d = f_q;
        if (clear) begin
            p_d = '0;
            f_d = '0;
        end else if (advance && !last_issue) begin
            if (f_q == F_LAST) begin
                f_d = '0;
                p_d = p_q + 1'b1;
            end else begin
                f_d = f_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            f_q <= '0;
        end else begin
            p_q <= p_d;
            f_q <= f_d;
        end
    end

    // Address arithmetic carried out at full address width
    always_comb begin
        p_ext      = ADDR_WIDTH'(p_q);
        f_ext      = ADDR_WIDTH'(f_q);
        addr_rd    = OUTPUT_BASE + p_ext * K_A + f_ext;
        dest_addr  = FMAP_BASE + f_ext * M_A + p_ext;
        last_issue = (p_q == P_LAST) && (f_q == F_LAST);
    end

endmodule : col2im_addr_gen
`default_nettype wire

// File: rtl/col2im.sv
`default_nettype none
// ============================================================================
//  Module      : col2im
//  Description : Inverse of im2col. Streams the M x K result matrix from
//                OUTPUT_BASE and rewrites it channel-major [filter][h][w] at
//                FMAP_BASE, one read issued and one write retired per cycle.
//  Config      : COL2IM_RELU_EN - when defined, negative words are written
//                as zero (signed ReLU on the write path).
//  Revision    : 1.0 - initial release
// ============================================================================
module col2im
    import pe_pkg::*;
#(
    parameter int                    IMG_H       = 5,
    parameter int                    IMG_W       = 5,
    parameter int                    FILTER_NUM  = 7,
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(OUTPUT_BASE_DEFAULT),
    parameter logic [ADDR_WIDTH-1:0] FMAP_BASE   = ADDR_WIDTH'(FMAP_BASE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_rd,
    output logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic [DATA_WIDTH-1:0] data_wr,
    output logic                  mem_wr_en,
    output logic                  busy,
    output logic                  done
);

    state_e                  state_q, state_d;
    logic                    wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0]   addr_wr_q, addr_wr_d;
    logic                    cnt_clear;
    logic                    cnt_advance;
    logic                    last_issue;
    logic [ADDR_WIDTH-1:0]   dest_addr;
    logic [DATA_WIDTH-1:0]   data_relu;

    col2im_addr_gen #(
        .IMG_H       (IMG_H),
        .IMG_W       (IMG_W),
        .FILTER_NUM  (FILTER_NUM),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .OUTPUT_BASE (OUTPUT_BASE),
        .FMAP_BASE   (FMAP_BASE)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .advance    (cnt_advance),
        .addr_rd    (addr_rd),
        .dest_addr  (dest_addr),
        .last_issue (last_issue)
    );

    // Sequencer: start is only honoured from IDLE or DONE; RUN issues one
    // read per cycle and FLUSH retires the last in-flight write
    always_comb begin
        state_d     = state_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    cnt_clear = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_advance = 1'b1;
                if (last_issue) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write pipeline capture: every RUN cycle's read becomes next cycle's write
    always_comb begin
        wr_valid_d = (state_q == ST_RUN);
        addr_wr_d  = wr_valid_d ? dest_addr : addr_wr_q;
    end

    // State and write-pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_valid_q <= 1'b0;
            addr_wr_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_valid_q <= wr_valid_d;
            addr_wr_q  <= addr_wr_d;
        end
    end

    // Optional ReLU on the write path; latency is unaffected either way
    always_comb begin
`ifdef COL2IM_RELU_EN
        data_relu = data_rd[DATA_WIDTH-1] ? '0 : data_rd;
`else
        data_relu = data_rd;
`endif
    end

    // Outputs; the write strobe is gated by rst so a reset cycle never commits
    always_comb begin
        mem_wr_en = wr_valid_q & ~rst;
        addr_wr   = addr_wr_q;
        data_wr   = wr_valid_q ? data_relu : '0;
        busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
        done      = (state_q == ST_DONE);
    end

endmodule : col2im
`default_nettype wire
